weight_ram_loader: RTL and testbench

Write-side feeder for the float16 weight RAM. Accepts a serial valid/ready stream of 16-bit weights, packs every kernel_size×kernel_size words into one zero-padded KERNEL_SIZE_MAX² slice, and issues one write pulse per slice (ena_w, addr_write, din) at consecutive addresses from a base. It sits between the off-chip/host weight fetch path and the weight RAM write port, and is controlled by the layer sequencer through a start/done handshake.

---
 rtl/weight_ram_loader.sv | 152 +++++++++++++++
 tb/tb_weight_ram_loader.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/weight_ram_loader.sv
// Packs a serial stream of k*k weights per slice into zero-padded KERNEL_SIZE_MAX^2 words and writes one slice per RAM strobe.
// The stream stalls by dropping in_ready while a slice is written; requests are taken only when idle.
module weight_ram_loader #(
  parameter int DATA_WIDTH      = 16,
  parameter int KERNEL_SIZE_MAX = 5,
  parameter int ADDR_WIDTH      = 10,
  parameter int SLICE_CNT_WIDTH = 10
) (
  input  logic                                                clk,
  input  logic                                                rst_n,
  input  logic                                                start,
  input  logic [2:0]                                          kernel_size,
  input  logic [SLICE_CNT_WIDTH-1:0]                          slice_count,
  input  logic [ADDR_WIDTH-1:0]                               base_addr,
  input  logic                                                in_valid,
  input  logic [DATA_WIDTH-1:0]                               in_data,
  output logic                                                in_ready,
  output logic                                                ena_w,
  output logic [ADDR_WIDTH-1:0]                               addr_write,
  output logic [KERNEL_SIZE_MAX*KERNEL_SIZE_MAX*DATA_WIDTH-1:0] din,
  output logic                                                busy,
  output logic                                                done,
  output logic                                                err
);

  localparam int SLOTS = KERNEL_SIZE_MAX * KERNEL_SIZE_MAX;
  localparam int WCW   = $clog2(SLOTS + 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_WRITE   = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  logic [1:0]                 state_q, state_d;
  logic [WCW-1:0]             k_sq_q, k_sq_d;
  logic [WCW-1:0]             word_cnt_q, word_cnt_d;
  logic [SLICE_CNT_WIDTH-1:0] slice_cnt_q, slice_cnt_d;
  logic [SLICE_CNT_WIDTH-1:0] slice_idx_q, slice_idx_d;
  logic [ADDR_WIDTH-1:0]      base_q, base_d;
  logic                       err_flag_q, err_flag_d;
  logic [SLOTS*DATA_WIDTH-1:0] slice_buf_q, slice_buf_d;

  logic                  in_ready_q, ena_w_q, busy_q, done_q, err_q;
  logic [ADDR_WIDTH-1:0] addr_q;

  logic [5:0] k_sq6;
  logic       accept;

  assign k_sq6  = {3'b000, kernel_size} * {3'b000, kernel_size};
  assign accept = in_valid && in_ready_q;

  always_comb begin
    state_d     = state_q;
    k_sq_d      = k_sq_q;
    word_cnt_d  = word_cnt_q;
    slice_cnt_d = slice_cnt_q;
    slice_idx_d = slice_idx_q;
    base_d      = base_q;
    err_flag_d  = err_flag_q;
    slice_buf_d = slice_buf_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          k_sq_d      = WCW'(k_sq6);
          slice_cnt_d = slice_count;
          base_d      = base_addr;
          slice_idx_d = '0;
          word_cnt_d  = '0;
          if (kernel_size == 3'd0 || kernel_size > 3'(KERNEL_SIZE_MAX)) begin
            err_flag_d = 1'b1;
            state_d    = S_DONE;
          end else if (slice_count == '0) begin
            err_flag_d = 1'b0;
            state_d    = S_DONE;
          end else begin
            err_flag_d = 1'b0;
            state_d    = S_COLLECT;
          end
        end
      end
      S_COLLECT: begin
        if (accept) begin
          slice_buf_d[int'(word_cnt_q)*DATA_WIDTH +: DATA_WIDTH] = in_data;
          word_cnt_d = word_cnt_q + WCW'(1);
          if (word_cnt_q == k_sq_q - WCW'(1)) begin
            state_d = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        // The slice has been presented this cycle; start the next one from an all-zero buffer.
        slice_buf_d = '0;
        word_cnt_d  = '0;
        if (slice_idx_q == slice_cnt_q - SLICE_CNT_WIDTH'(1)) begin
          state_d = S_DONE;
        end else begin
          slice_idx_d = slice_idx_q + SLICE_CNT_WIDTH'(1);
          state_d     = S_COLLECT;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      k_sq_q      <= '0;
      word_cnt_q  <= '0;
      slice_cnt_q <= '0;
      slice_idx_q <= '0;
      base_q      <= '0;
      err_flag_q  <= 1'b0;
      slice_buf_q <= '0;
      in_ready_q  <= 1'b0;
      ena_w_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      addr_q      <= '0;
    end else begin
      state_q     <= state_d;
      k_sq_q      <= k_sq_d;
      word_cnt_q  <= word_cnt_d;
      slice_cnt_q <= slice_cnt_d;
      slice_idx_q <= slice_idx_d;
      base_q      <= base_d;
      err_flag_q  <= err_flag_d;
      slice_buf_q <= slice_buf_d;
      // Strobes are decoded from the next state so they line up with the state they describe.
      in_ready_q  <= (state_d == S_COLLECT);
      ena_w_q     <= (state_d == S_WRITE);
      busy_q      <= (state_d != S_IDLE);
      done_q      <= (state_d == S_DONE);
      err_q       <= (state_d == S_DONE) && err_flag_d;
      if (state_d == S_WRITE) begin
        addr_q <= base_q + ADDR_WIDTH'(slice_idx_d);
      end
    end
  end

  assign in_ready   = in_ready_q;
  assign ena_w      = ena_w_q;
  assign addr_write = addr_q;
  assign din        = slice_buf_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_weight_ram_loader.sv
// Bench for weight_ram_loader: a slice-level model predicts every RAM write and completion status from the words streamed in.
module tb_weight_ram_loader;

  localparam int DW = 16;
  localparam int KM = 5;
  localparam int AW = 10;
  localparam int SW = 10;
  localparam int SL = KM * KM;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [2:0]        kernel_size = '0;
  logic [SW-1:0]     slice_count = '0;
  logic [AW-1:0]     base_addr = '0;
  logic              in_valid = 1'b0;
  logic [DW-1:0]     in_data = '0;
  logic              in_ready;
  logic              ena_w;
  logic [AW-1:0]     addr_write;
  logic [SL*DW-1:0]  din;
  logic              busy;
  logic              done;
  logic              err;

  weight_ram_loader #(
    .DATA_WIDTH(DW), .KERNEL_SIZE_MAX(KM), .ADDR_WIDTH(AW), .SLICE_CNT_WIDTH(SW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .kernel_size(kernel_size),
    .slice_count(slice_count), .base_addr(base_addr), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .ena_w(ena_w), .addr_write(addr_write),
    .din(din), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [AW-1:0]    exp_addr_q[$];
  logic [SL*DW-1:0] exp_din_q[$];
  logic             exp_err = 1'b0;
  logic [AW-1:0]    addr_log[$];
  logic [SL*DW-1:0] din_log[$];
  logic [DW-1:0]    stream_w[$];
  bit               no_ready_chk = 1'b0;

  task automatic chk(input string name, input logic [SL*DW-1:0] act, input logic [SL*DW-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  // Expected writes follow directly from slicing the word stream into k*k chunks.
  task automatic push_load(input int k, input int n, input logic [AW-1:0] base);
    logic [SL*DW-1:0] d;
    exp_err = (k < 1 || k > KM);
    if (!exp_err) begin
      for (int s = 0; s < n; s++) begin
        d = '0;
        for (int j = 0; j < k * k; j++) d[j*DW +: DW] = stream_w[s*k*k + j];
        exp_addr_q.push_back(AW'(int'(base) + s));
        exp_din_q.push_back(d);
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (ena_w) begin
        if (exp_addr_q.size() == 0) begin
          chk("unexpected_write", ena_w, 0);
        end else begin
          chk("addr_write", addr_write, exp_addr_q.pop_front());
          chk("din", din, exp_din_q.pop_front());
          addr_log.push_back(addr_write);
          din_log.push_back(din);
        end
      end
      if (done) begin
        chk("done_err", err, exp_err);
        chk("writes_left_at_done", exp_addr_q.size(), 0);
      end
      if (err) chk("err_needs_done", done, 1);
      if (no_ready_chk) chk("in_ready_idle_req", in_ready, 0);
    end
  end

  task automatic drive_stream(input bit gappy);
    int i = 0;
    int cyc = 0;
    bit hs;
    while (i < stream_w.size() && cyc < 2000) begin
      in_valid = !gappy || (cyc % 2 == 0);
      in_data  = stream_w[i];
      @(negedge clk);
      hs = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (hs) i++;
      cyc++;
    end
    in_valid = 1'b0;
    in_data  = '0;
    if (i < stream_w.size()) chk("stream_timeout", i, stream_w.size());
  endtask

  task automatic do_start(input int k, input int n, input logic [AW-1:0] base);
    kernel_size = 3'(k);
    slice_count = SW'(n);
    base_addr   = base;
    start       = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // cyc = 1 means done arrived in the cycle right after the start edge.
  task automatic wait_done(output int cyc);
    cyc = 1;
    while (1) begin
      @(negedge clk);
      chk("busy_during_load", busy, 1);
      if (done) break;
      if (cyc >= 3000) begin
        n_cmp++;
        n_bad++;
        $display("FAIL done_timeout: got no done after %0d cycles, want done", cyc);
        break;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_load(input int k, input int n, input logic [AW-1:0] base, input bit gappy, output int cyc);
    int c;
    fork
      drive_stream(gappy);
      begin
        do_start(k, n, base);
        wait_done(c);
      end
    join
    cyc = c;
    @(negedge clk);
    chk("busy_after_done", busy, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic set_stream(input logic [DW-1:0] first, input int len);
    stream_w.delete();
    for (int i = 0; i < len; i++) stream_w.push_back(first + DW'(i));
    addr_log.delete();
    din_log.delete();
  endtask

  initial begin
    int cyc;
    logic [SL*DW-1:0] d;
    logic [DW-1:0] w;

    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_ena_w", ena_w, 0);
    chk("rst_addr", addr_write, 0);
    chk("rst_din", din, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Reset mid-collect after 4 of 9 words: nothing written, outputs clear at once.
    set_stream(16'h5000, 4);
    fork
      drive_stream(1'b0);
      do_start(3, 1, 10'h000);
    join
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("pre_rst_in_ready", in_ready, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_in_ready", in_ready, 0);
    chk("arst_busy", busy, 0);
    chk("arst_din", din, 0);
    chk("arst_ena_w", ena_w, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    set_stream(16'h6000, 9);
    push_load(3, 1, 10'h005);
    run_load(3, 1, 10'h005, 1'b0, cyc);
    chk("post_rst_writes", din_log.size(), 1);

    // k=3, two slices, continuous stream.
    set_stream(16'h3C00, 18);
    push_load(3, 2, 10'h010);
    run_load(3, 2, 10'h010, 1'b0, cyc);
    chk("k3_start_to_done", cyc, 21);
    chk("k3_nwrites", addr_log.size(), 2);
    if (addr_log.size() == 2) begin
      chk("k3_addr0", addr_log[0], 10'h010);
      chk("k3_addr1", addr_log[1], 10'h011);
      d = din_log[0];
      w = d[0 +: DW];
      chk("k3_s0_slot0", w, 16'h3C00);
      w = d[8*DW +: DW];
      chk("k3_s0_slot8", w, 16'h3C08);
      chk("k3_s0_pad", d[SL*DW-1:9*DW], 0);
      d = din_log[1];
      w = d[0 +: DW];
      chk("k3_s1_slot0", w, 16'h3C09);
    end

    // k=5, one slice, in_valid toggling.
    set_stream(16'h4000, 25);
    push_load(5, 1, 10'h100);
    run_load(5, 1, 10'h100, 1'b1, cyc);
    chk("k5_nwrites", din_log.size(), 1);
    if (din_log.size() == 1) begin
      d = din_log[0];
      w = d[24*DW +: DW];
      chk("k5_slot24", w, 16'h4018);
      w = d[12*DW +: DW];
      chk("k5_slot12", w, 16'h400C);
    end

    // k=1, address wraps past the top of the RAM.
    set_stream(16'hA001, 3);
    push_load(1, 3, 10'h3FF);
    run_load(1, 3, 10'h3FF, 1'b0, cyc);
    chk("k1_start_to_done", cyc, 7);
    chk("k1_nwrites", addr_log.size(), 3);
    if (addr_log.size() == 3) begin
      chk("k1_addr0", addr_log[0], 10'h3FF);
      chk("k1_addr1", addr_log[1], 10'h000);
      chk("k1_addr2", addr_log[2], 10'h001);
      chk("k1_din2", din_log[2], {{(SL-1)*DW{1'b0}}, 16'hA003});
    end

    // Zero-slice and illegal-kernel requests complete immediately without writes.
    set_stream(16'h0000, 0);
    no_ready_chk = 1'b1;
    push_load(3, 0, 10'h000);
    run_load(3, 0, 10'h000, 1'b0, cyc);
    chk("zero_slices_cyc", cyc, 1);
    push_load(0, 2, 10'h000);
    run_load(0, 2, 10'h000, 1'b0, cyc);
    chk("k0_cyc", cyc, 1);
    push_load(6, 2, 10'h000);
    run_load(6, 2, 10'h000, 1'b0, cyc);
    chk("k6_cyc", cyc, 1);
    no_ready_chk = 1'b0;
    exp_err = 1'b0;

    // A second start during COLLECT must not disturb the load in flight.
    set_stream(16'h7000, 4);
    push_load(2, 1, 10'h020);
    fork
      drive_stream(1'b0);
      begin
        do_start(2, 1, 10'h020);
        fork
          wait_done(cyc);
          begin
            repeat (2) @(posedge clk);
            #1;
            kernel_size = 3'd4;
            slice_count = SW'(3);
            base_addr   = 10'h100;
            start       = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
          end
        join
      end
    join
    chk("ignored_start_cyc", cyc, 6);
    repeat (8) @(posedge clk);
    #1;
    chk("ignored_start_nwrites", addr_log.size(), 1);
    if (addr_log.size() == 1) chk("ignored_start_addr", addr_log[0], 10'h020);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
